booth_mul_sched: RTL

Shares one iterative radix-2 Booth multiplier among NREQ requesters. A round-robin arbiter picks one pending request and loads its operands. The block then runs the Booth recode/add/arithmetic-shift sequence one bit per clock and returns the signed product tagged with the requester index. It sits between the requesting engines and the arithmetic datapath, and replaces the fully unrolled combinational multiplier where area matters more than latency.

---
 rtl/booth_mul_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/booth_mul_sched.sv
// booth_mul_sched
//   Shares one iterative radix-2 Booth multiplier among NREQ requesters.
//   A round-robin arbiter grants one pending requester while idle, its
//   operand pair is loaded, and the recode/add/shift sequence runs one bit
//   per clock for WIDTH clocks. The signed 2*WIDTH-bit product is then
//   presented with the owning requester index until the consumer takes it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   [NREQ]          per-requester valid
//   req_ready   [NREQ]          one-hot grant, only while idle
//   req_m       [NREQ*WIDTH]    multiplicands, slice i at [i*WIDTH +: WIDTH]
//   req_q       [NREQ*WIDTH]    multipliers, same layout
//   resp_valid                  product available
//   resp_ready                  consumer accepts the product
//   resp_id     [IDW]           requester that owns resp_prod
//   resp_prod   [2*WIDTH]       signed product
//   busy                        high whenever not idle
module booth_mul_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_m,
    input  logic [NREQ*WIDTH-1:0]   req_q,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [2*WIDTH-1:0]      resp_prod,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IDW-1:0]           ptr;
    logic [IDW-1:0]           grant;
    logic                     grant_vld;
    logic [CW-1:0]            count;
    logic [IDW-1:0]           tag;
    logic                     last_iter;

    // Booth working registers: accumulator A is one bit wider than the
    // operands so that subtracting the most negative M cannot overflow.
    logic signed [WIDTH-1:0]  m_reg;
    logic signed [WIDTH:0]    acc;
    logic [WIDTH-1:0]         q_reg;
    logic                     q1;
    logic [2*WIDTH+1:0]       step;

    // One Booth iteration: recode {Q[0], q1}, add/subtract M into A, then
    // arithmetic-shift {A, Q, q1} right by one. Concatenating the sign bit
    // of the new A in front of {A, Q} and dropping nothing yields exactly
    // the shifted triple {A', Q', q1'}.
    function automatic logic [2*WIDTH+1:0] booth_step(
        input logic signed [WIDTH:0]   a,
        input logic [WIDTH-1:0]        q,
        input logic                    qm1,
        input logic signed [WIDTH-1:0] m
    );
        logic signed [WIDTH:0] mext;
        logic signed [WIDTH:0] sum;
        mext = {m[WIDTH-1], m};
        case ({q[0], qm1})
            2'b01:   sum = a + mext;
            2'b10:   sum = a - mext;
            default: sum = a;
        endcase
        return {sum[WIDTH], sum, q};
    endfunction

    assign step      = booth_step(acc, q_reg, q1, m_reg);
    assign last_iter = (count == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant     = IDW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_vld)  state_next = RUN;
            RUN:     if (last_iter)  state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            count      <= '0;
            tag        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_prod  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ptr   <= grant;
                        tag   <= grant;
                        count <= '0;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (last_iter) begin
                        resp_prod  <= step[2*WIDTH:1];
                        resp_id    <= tag;
                        resp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; no reset needed since they are always loaded on
    // a grant before being used.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_vld) begin
            m_reg <= req_m[int'(grant)*WIDTH +: WIDTH];
            q_reg <= req_q[int'(grant)*WIDTH +: WIDTH];
            acc   <= '0;
            q1    <= 1'b0;
        end else if (state == RUN) begin
            {acc, q_reg, q1} <= step;
        end
    end

endmodule
